ws2812_rx: RTL and testbench
============================

# ws2812_rx

- Receives a WS2812 single-wire serial stream and decodes it into 24-bit pixel words in arrival order.
- Also reports the pixel index within the frame and flags frame boundaries and protocol errors.
- It is the receiving end of the strip protocol driven by `neopixel_controller`.
- Uses: loopback verification of the POV strip driver on hardware, and accepting pixel streams from an external WS2812-style source into the texture path.

## Interface

Parameters
- `CLK_HZ`, 100_000_000: clock frequency; documentation only, all thresholds are given in cycles.
- `BITS_PER_PIXEL`, 24: bits per pixel word, shifted in MSB first.
- `PX_COUNT_WIDTH`, 6: width of the pixel index and count outputs.
- `MIN_HIGH`, 15: high pulses shorter than this many cycles (<150 ns) are a glitch error.
- `BIT_THRESH`, 60: high pulses of ≥ this many cycles decode as 1; shorter pulses decode as 0.
- `MAX_HIGH`, 150: high pulses longer than this many cycles are an error.
- `RESET_LOW`, 5000: a low interval of this many cycles (50 µs) is a latch/reset gap and marks frame end.

Ports
- `clk`, in, 1: single clock domain, 100 MHz.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `din`, in, 1: raw WS2812 line; asynchronous to `clk`.
- `pixel`, out, `BITS_PER_PIXEL`: last decoded word, GRB order as on the wire; held between updates.
- `px_valid`, out, 1: one-cycle pulse; `pixel` and `px_num` are valid on this cycle.
- `px_num`, out, `PX_COUNT_WIDTH`: index of `pixel` within the current frame, starting at 0.
- `frame_done`, out, 1: one-cycle pulse at the end of a frame.
- `frame_px_count`, out, `PX_COUNT_WIDTH`: number of whole pixels in the completed frame; updated together with `frame_done`.
- `err`, out, 1: one-cycle pulse on any protocol violation.

## Operation

- `din` passes through a 2-flop synchronizer to give `s`; a registered copy `s_d` is used for edge detection.
- Counters:
  - `low_cnt` and `high_cnt` are `$clog2(RESET_LOW+1)` bits wide and saturate at all-ones.
  - `bit_cnt` runs from 0 to `BITS_PER_PIXEL`-1.
  - An internal pixel counter tracks the index of the next pixel.

FSM states
- **SYNC** (state after reset)
  - Ignores all edges.
  - Counts consecutive low cycles of `s`; any high clears the count.
  - When the count reaches `RESET_LOW`, moves to LOW with all counters cleared. This prevents joining a stream mid-frame.
- **LOW**
  - Increments `low_cnt` while `s` is low.
  - On a rising edge, moves to HIGH with `high_cnt` = 1.
  - When `low_cnt` reaches `RESET_LOW`, a frame ends:
    - If at least one pixel or bit was received, pulse `frame_done` and load `frame_px_count` with the pixel counter.
    - If `bit_cnt` ≠ 0, also pulse `err` and discard the partial word.
    - Clear the pixel counter and `bit_cnt`, then stay in LOW. No further `frame_done` is issued until new bits arrive.
- **HIGH**
  - Increments `high_cnt` while `s` is high.
  - On a falling edge, classify the pulse:
    - `high_cnt` < `MIN_HIGH`: pulse `err`, go to SYNC.
    - Otherwise shift the bit in as (`high_cnt` ≥ `BIT_THRESH`), set `low_cnt` = 1, and go to LOW.
  - If `high_cnt` exceeds `MAX_HIGH` while still high: pulse `err`, go to SYNC.
- **Word completion**
  - When the 24th bit is shifted in, register the word into `pixel` and pulse `px_valid` with `px_num` = pixel counter.
  - Then increment the pixel counter and clear `bit_cnt`.
- **Pixel overflow**
  - When the pixel counter is all-ones and another word completes, the word is dropped: no `px_valid`, `err` pulses, and the counter saturates.
  - `frame_px_count` then reports all-ones.
- **Error recovery:** every error path through SYNC discards the partial word and the frame state. No `frame_done` is issued for an aborted frame.

## Timing

- Reset values:
  - `pixel` = 0, `px_num` = 0, `frame_px_count` = 0.
  - `px_valid`, `frame_done`, `err` = 0.
  - State = SYNC; all counters = 0.
- Latency:
  - `px_valid` asserts exactly 3 `clk` cycles after the `din` falling edge that ends the last bit of a word (2 synchronizer cycles + 1 registered output).
  - `frame_done` asserts `RESET_LOW`+3 cycles after the last `din` falling edge.
- There is no backpressure; the consumer must accept every `px_valid`. The minimum spacing between pulses is one WS2812 word, about 24 × 125 cycles.
- Simultaneous events: an edge and a threshold crossing in the same cycle resolve in favour of the edge.
- Asynchronous deassertion of `reset_n` is released into the synchronizer flops; the first edges are then ignored because the FSM starts in SYNC.

## Structure

- Shared package `ws2812_pkg` holds:
  - the timing constants (T0H = 40, T1H = 80, period = 125, reset = 5000 cycles at 100 MHz);
  - `BITS_PER_PIXEL`;
  - the derived thresholds.
- The transmitter testbench uses the same package.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with async active-low reset to 0, reusable elsewhere for external inputs.
- The FSM, counters and shift register stay in `ws2812_rx`.

## Test plan

1. **Single pixel:** after a 60 µs low, send one pixel 0xA53C0F (T0H = 400 ns, T1H = 800 ns), then 60 µs low.
   - Required: one `px_valid` with `pixel` = 0xA53C0F and `px_num` = 0.
   - Required: `frame_done` with `frame_px_count` = 1 and no `err`.
2. **Loopback:** drive `din` from `neopixel_controller` (52 pixels, value index×0x010203) for two frames.
   - Required: 52 `px_valid` pulses per frame with `px_num` 0..51 and matching values.
   - Required: `frame_px_count` = 52.
3. **Glitch:** insert a 100 ns high pulse mid-word.
   - Required: `err` pulses and the partial pixel is lost.
   - Required: no `px_valid` until after the next ≥ 50 µs low; the following frame decodes correctly.
4. **Partial word:** send 12 bits, then a 60 µs low.
   - Required: `err` and `frame_done` pulse with `frame_px_count` = 0 and no `px_valid`.
5. **Stuck high:** hold `din` high for 2 µs.
   - Required: `err` pulses once; the block recovers only after a 50 µs low.
6. **Reset mid-frame:** assert `reset_n` = 0 during pixel 3 of 10.
   - Required: all outputs return to their reset values immediately.
   - Required: the rest of that frame is ignored and the next frame decodes from `px_num` = 0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared WS2812 line timing for the strip transmitter, the
// receiver and their benches.
//   - Nominal pulse timings in clock cycles at 100 MHz.
//   - Pixel word width (GRB, MSB first on the wire).
//   - Receiver decision thresholds derived from the nominal timings.
//   - Receiver FSM state type.
package ws2812_pkg;

    localparam int CLK_HZ_DEFAULT = 100_000_000;

    // Nominal wire timing, cycles at 100 MHz
    localparam int T0H_CYC    = 40;    // 400 ns high for a 0 bit
    localparam int T1H_CYC    = 80;    // 800 ns high for a 1 bit
    localparam int TBIT_CYC   = 125;   // 1.25 us bit period
    localparam int TRESET_CYC = 5000;  // 50 us latch gap

    localparam int BITS_PER_PIXEL = 24;

    // Receiver thresholds
    localparam int MIN_HIGH_CYC   = 15;                         // below: glitch
    localparam int BIT_THRESH_CYC = (T0H_CYC + T1H_CYC) / 2;    // 60: 0/1 split
    localparam int MAX_HIGH_CYC   = 150;                        // above: stuck
    localparam int RESET_LOW_CYC  = TRESET_CYC;

    typedef enum logic [1:0] {
        RX_SYNC = 2'd0,
        RX_LOW  = 2'd1,
        RX_HIGH = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, both flops clear to 0
//   d     - asynchronous input
//   q     - synchronized output, two clk cycles behind d
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_p0 <= '0;
            q    <= '0;
        end else begin
            d_p0 <= d;
            q    <= d_p0;
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 single-wire stream into pixel words.
//   clk            - system clock
//   reset_n        - asynchronous active-low reset
//   din            - raw WS2812 line, asynchronous to clk
//   pixel          - last decoded word (GRB as on the wire), held
//   px_valid       - one-cycle pulse, pixel/px_num valid
//   px_num         - index of pixel within the current frame
//   frame_done     - one-cycle pulse when a latch gap ends a frame
//   frame_px_count - whole pixels in the completed frame
//   err            - one-cycle pulse on any protocol violation
module ws2812_rx #(
    parameter int CLK_HZ         = ws2812_pkg::CLK_HZ_DEFAULT,
    parameter int BITS_PER_PIXEL = ws2812_pkg::BITS_PER_PIXEL,
    parameter int PX_COUNT_WIDTH = 6,
    parameter int MIN_HIGH       = ws2812_pkg::MIN_HIGH_CYC,
    parameter int BIT_THRESH     = ws2812_pkg::BIT_THRESH_CYC,
    parameter int MAX_HIGH       = ws2812_pkg::MAX_HIGH_CYC,
    parameter int RESET_LOW      = ws2812_pkg::RESET_LOW_CYC
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      din,
    output logic [BITS_PER_PIXEL-1:0] pixel,
    output logic                      px_valid,
    output logic [PX_COUNT_WIDTH-1:0] px_num,
    output logic                      frame_done,
    output logic [PX_COUNT_WIDTH-1:0] frame_px_count,
    output logic                      err
);
    import ws2812_pkg::*;

    localparam int CW  = $clog2(RESET_LOW + 1);
    localparam int BCW = $clog2(BITS_PER_PIXEL);

    localparam logic [CW-1:0]  MIN_HIGH_C   = CW'(MIN_HIGH);
    localparam logic [CW-1:0]  BIT_THRESH_C = CW'(BIT_THRESH);
    localparam logic [CW-1:0]  MAX_HIGH_C   = CW'(MAX_HIGH);
    localparam logic [CW-1:0]  RESET_LOW_C  = CW'(RESET_LOW);
    localparam logic [BCW-1:0] BIT_LAST_C   = BCW'(BITS_PER_PIXEL - 1);

    if (CLK_HZ <= 0 || MIN_HIGH >= BIT_THRESH || BIT_THRESH > MAX_HIGH ||
        MAX_HIGH >= RESET_LOW) begin : g_bad_params
        $error("ws2812_rx: inconsistent timing parameters");
    end

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    rx_state_t                 state, state_nx;
    logic                      s, s_d, rise, fall, bit_val;
    logic [CW-1:0]             low_cnt, low_cnt_nx, high_cnt, high_cnt_nx;
    logic [BCW-1:0]            bit_cnt, bit_cnt_nx;
    logic [PX_COUNT_WIDTH-1:0] px_cnt, px_cnt_nx;
    logic [BITS_PER_PIXEL-2:0] shreg, shreg_nx;
    logic [BITS_PER_PIXEL-1:0] word, pixel_nx;
    logic [PX_COUNT_WIDTH-1:0] px_num_nx, frame_px_count_nx;
    logic                      px_valid_nx, frame_done_nx, err_nx;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (din),
        .q     (s)
    );

    assign rise    = s & ~s_d;
    assign fall    = ~s & s_d;
    assign bit_val = (high_cnt >= BIT_THRESH_C);
    assign word    = {shreg, bit_val};

    always_comb begin
        state_nx          = state;
        low_cnt_nx        = low_cnt;
        high_cnt_nx       = high_cnt;
        bit_cnt_nx        = bit_cnt;
        px_cnt_nx         = px_cnt;
        shreg_nx          = shreg;
        pixel_nx          = pixel;
        px_num_nx         = px_num;
        frame_px_count_nx = frame_px_count;
        px_valid_nx       = 1'b0;
        frame_done_nx     = 1'b0;
        err_nx            = 1'b0;

        unique case (state)
            // Wait for a full latch gap so we never start decoding mid-frame.
            RX_SYNC: begin
                if (s) begin
                    low_cnt_nx = '0;
                end else if (low_cnt == RESET_LOW_C) begin
                    state_nx    = RX_LOW;
                    low_cnt_nx  = '0;
                    high_cnt_nx = '0;
                    bit_cnt_nx  = '0;
                    px_cnt_nx   = '0;
                    shreg_nx    = '0;
                end else begin
                    low_cnt_nx = sat_inc(low_cnt);
                end
            end

            RX_LOW: begin
                if (rise) begin
                    state_nx    = RX_HIGH;
                    high_cnt_nx = CW'(1);
                end else if (!s) begin
                    low_cnt_nx = sat_inc(low_cnt);
                    // Saturation past RESET_LOW makes this fire once per gap.
                    if (low_cnt == RESET_LOW_C) begin
                        if (px_cnt != '0 || bit_cnt != '0) begin
                            frame_done_nx     = 1'b1;
                            frame_px_count_nx = px_cnt;
                        end
                        if (bit_cnt != '0) begin
                            err_nx = 1'b1;
                        end
                        px_cnt_nx  = '0;
                        bit_cnt_nx = '0;
                        shreg_nx   = '0;
                    end
                end
            end

            RX_HIGH: begin
                if (fall) begin
                    if (high_cnt < MIN_HIGH_C) begin
                        err_nx      = 1'b1;
                        state_nx    = RX_SYNC;
                        low_cnt_nx  = '0;
                        high_cnt_nx = '0;
                        bit_cnt_nx  = '0;
                        px_cnt_nx   = '0;
                        shreg_nx    = '0;
                    end else begin
                        state_nx   = RX_LOW;
                        low_cnt_nx = CW'(1);
                        if (bit_cnt == BIT_LAST_C) begin
                            bit_cnt_nx = '0;
                            shreg_nx   = '0;
                            // A full counter means the index space is used up.
                            if (&px_cnt) begin
                                err_nx = 1'b1;
                            end else begin
                                pixel_nx    = word;
                                px_valid_nx = 1'b1;
                                px_num_nx   = px_cnt;
                                px_cnt_nx   = px_cnt + 1'b1;
                            end
                        end else begin
                            bit_cnt_nx = bit_cnt + 1'b1;
                            shreg_nx   = word[BITS_PER_PIXEL-2:0];
                        end
                    end
                end else if (high_cnt > MAX_HIGH_C) begin
                    err_nx      = 1'b1;
                    state_nx    = RX_SYNC;
                    low_cnt_nx  = '0;
                    high_cnt_nx = '0;
                    bit_cnt_nx  = '0;
                    px_cnt_nx   = '0;
                    shreg_nx    = '0;
                end else begin
                    high_cnt_nx = sat_inc(high_cnt);
                end
            end

            default: state_nx = RX_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RX_SYNC;
            s_d            <= 1'b0;
            low_cnt        <= '0;
            high_cnt       <= '0;
            bit_cnt        <= '0;
            px_cnt         <= '0;
            shreg          <= '0;
            pixel          <= '0;
            px_num         <= '0;
            frame_px_count <= '0;
            px_valid       <= 1'b0;
            frame_done     <= 1'b0;
            err            <= 1'b0;
        end else begin
            state          <= state_nx;
            s_d            <= s;
            low_cnt        <= low_cnt_nx;
            high_cnt       <= high_cnt_nx;
            bit_cnt        <= bit_cnt_nx;
            px_cnt         <= px_cnt_nx;
            shreg          <= shreg_nx;
            pixel          <= pixel_nx;
            px_num         <= px_num_nx;
            frame_px_count <= frame_px_count_nx;
            px_valid       <= px_valid_nx;
            frame_done     <= frame_done_nx;
            err            <= err_nx;
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed bench for ws2812_rx. Line timing is scaled down
// (thresholds 4/8/16, latch gap 200 cycles) so that full 52- and 64-pixel
// frames fit in a short run; the decision boundaries keep the same shape.
module tb_ws2812_rx;
    import ws2812_pkg::*;

    localparam int PXW     = 6;
    localparam int MIN_H   = 4;
    localparam int THRESH  = 8;
    localparam int MAX_H   = 16;
    localparam int RST_LOW = 200;
    localparam int T0H     = 5;
    localparam int T1H     = 10;
    localparam int TLOW    = 3;
    localparam int GAP     = 240;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      din;
    logic [BITS_PER_PIXEL-1:0] pixel;
    logic                      px_valid;
    logic [PXW-1:0]            px_num;
    logic                      frame_done;
    logic [PXW-1:0]            frame_px_count;
    logic                      err;

    int cyc = 0;
    int fall_cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int px_val_log[$];
    int px_num_log[$];
    int px_cyc_log[$];
    int fd_seen = 0;
    int err_seen = 0;
    int fd_cyc_last = 0;
    int fd_cnt_last = 0;
    int px0, fd0, er0, f;

    ws2812_rx #(
        .BITS_PER_PIXEL (BITS_PER_PIXEL),
        .PX_COUNT_WIDTH (PXW),
        .MIN_HIGH       (MIN_H),
        .BIT_THRESH     (THRESH),
        .MAX_HIGH       (MAX_H),
        .RESET_LOW      (RST_LOW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .din            (din),
        .pixel          (pixel),
        .px_valid       (px_valid),
        .px_num         (px_num),
        .frame_done     (frame_done),
        .frame_px_count (frame_px_count),
        .err            (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (px_valid) begin
            px_val_log.push_back(int'(pixel));
            px_num_log.push_back(int'(px_num));
            px_cyc_log.push_back(cyc);
        end
        if (frame_done) begin
            fd_seen     <= fd_seen + 1;
            fd_cnt_last <= int'(frame_px_count);
            fd_cyc_last <= cyc;
        end
        if (err) err_seen <= err_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
        end
    endtask

    task automatic pulse(input int w);
        din = 1'b1;
        repeat (w) @(negedge clk);
        din = 1'b0;
        fall_cyc = cyc;
        repeat (TLOW) @(negedge clk);
    endtask

    task automatic send_bits(input int v, input int nbits);
        for (int b = 23; b > 23 - nbits; b--) pulse(v[b] ? T1H : T0H);
    endtask

    task automatic send_pixel(input int v);
        send_bits(v, 24);
    endtask

    task automatic idle(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        px0 = px_val_log.size();
        fd0 = fd_seen;
        er0 = err_seen;
    endtask

    // Compare logged pixel k (relative to the mark) with an expected value/index.
    task automatic chk_px(input string tag, input int k, input int v, input int n);
        if (px0 + k < px_val_log.size()) begin
            chk($sformatf("%s_val%0d", tag, k), px_val_log[px0 + k], v);
            chk($sformatf("%s_num%0d", tag, k), px_num_log[px0 + k], n);
        end else begin
            chk($sformatf("%s_missing%0d", tag, k), px_val_log.size() - px0, k + 1);
        end
    endtask

    function automatic int ramp(input int i);
        return (i * 'h010203) & 'hFFFFFF;
    endfunction

    function automatic int steps(input int i);
        return (i + 1) * 'h111111;
    endfunction

    initial begin
        reset_n = 1'b0;
        din     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pixel", 32'(pixel), 0);
        chk("rst_px_valid", 32'(px_valid), 0);
        chk("rst_px_num", 32'(px_num), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_frame_px_count", 32'(frame_px_count), 0);
        chk("rst_err", 32'(err), 0);
        reset_n = 1'b1;

        // Single pixel with latency checks
        idle(GAP);
        mark();
        send_pixel('hA53C0F);
        f = fall_cyc;
        idle(GAP);
        chk("t1_px_count", px_val_log.size() - px0, 1);
        chk_px("t1", 0, 'hA53C0F, 0);
        if (px_cyc_log.size() > px0) chk("t1_px_latency", px_cyc_log[px0] - f, 3);
        chk("t1_fd_count", fd_seen - fd0, 1);
        chk("t1_fpc", fd_cnt_last, 1);
        chk("t1_fd_latency", fd_cyc_last - f, RST_LOW + 3);
        chk("t1_err", err_seen - er0, 0);

        // Pulse widths on each decision boundary: 8->1, 7->0, 4->0, 16->1
        mark();
        for (int i = 0; i < 24; i++) begin
            case (i % 4)
                0: pulse(THRESH);
                1: pulse(THRESH - 1);
                2: pulse(MIN_H);
                default: pulse(MAX_H);
            endcase
        end
        idle(GAP);
        chk("bnd_px_count", px_val_log.size() - px0, 1);
        chk_px("bnd", 0, 'h999999, 0);
        chk("bnd_err", err_seen - er0, 0);

        // Two 52-pixel ramp frames
        for (int fr = 0; fr < 2; fr++) begin
            mark();
            for (int i = 0; i < 52; i++) send_pixel(ramp(i));
            idle(GAP);
            chk($sformatf("t2_f%0d_px_count", fr), px_val_log.size() - px0, 52);
            for (int i = 0; i < 52; i++) chk_px($sformatf("t2_f%0d", fr), i, ramp(i), i);
            chk($sformatf("t2_f%0d_fd_count", fr), fd_seen - fd0, 1);
            chk($sformatf("t2_f%0d_fpc", fr), fd_cnt_last, 52);
            chk($sformatf("t2_f%0d_err", fr), err_seen - er0, 0);
        end

        // Glitch mid-word; rest of the frame must be ignored
        mark();
        send_bits('h123456, 10);
        pulse(MIN_H - 1);
        send_pixel('h00FF00);
        chk("t3_err", err_seen - er0, 1);
        idle(GAP);
        chk("t3_px_none", px_val_log.size() - px0, 0);
        chk("t3_fd_none", fd_seen - fd0, 0);
        mark();
        send_pixel('h0F1E2D);
        send_pixel('hF0E1D2);
        idle(GAP);
        chk("t3_px_count", px_val_log.size() - px0, 2);
        chk_px("t3", 0, 'h0F1E2D, 0);
        chk_px("t3", 1, 'hF0E1D2, 1);
        chk("t3_fpc", fd_cnt_last, 2);
        chk("t3_err_after", err_seen - er0, 0);

        // Partial word then latch gap
        mark();
        send_bits('hABCDEF, 12);
        idle(GAP);
        chk("t4_px_none", px_val_log.size() - px0, 0);
        chk("t4_fd_count", fd_seen - fd0, 1);
        chk("t4_fpc", fd_cnt_last, 0);
        chk("t4_err", err_seen - er0, 1);

        // Stuck high; a short low is not enough to recover
        mark();
        din = 1'b1;
        repeat (30) @(negedge clk);
        din = 1'b0;
        idle(100);
        send_pixel('h555555);
        idle(GAP);
        chk("t5_err_once", err_seen - er0, 1);
        chk("t5_px_none", px_val_log.size() - px0, 0);
        chk("t5_fd_none", fd_seen - fd0, 0);
        mark();
        send_pixel('h13579B);
        idle(GAP);
        chk("t5_px_count", px_val_log.size() - px0, 1);
        chk_px("t5", 0, 'h13579B, 0);
        chk("t5_fpc", fd_cnt_last, 1);

        // Reset during pixel 3 of 10
        mark();
        for (int i = 0; i < 3; i++) send_pixel(steps(i));
        send_bits(steps(3), 8);
        chk("t6_px_before", px_val_log.size() - px0, 3);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_pixel", 32'(pixel), 0);
        chk("t6_rst_px_num", 32'(px_num), 0);
        chk("t6_rst_fpc", 32'(frame_px_count), 0);
        chk("t6_rst_px_valid", 32'(px_valid), 0);
        chk("t6_rst_err", 32'(err), 0);
        chk("t6_rst_frame_done", 32'(frame_done), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mark();
        for (int i = 4; i < 10; i++) send_pixel(steps(i));
        idle(GAP);
        chk("t6_px_ignored", px_val_log.size() - px0, 0);
        chk("t6_fd_none", fd_seen - fd0, 0);
        mark();
        for (int i = 0; i < 3; i++) send_pixel(steps(i));
        idle(GAP);
        chk("t6_px_count", px_val_log.size() - px0, 3);
        for (int i = 0; i < 3; i++) chk_px("t6", i, steps(i), i);
        chk("t6_fpc", fd_cnt_last, 3);

        // 64 words: the last one overflows the 6-bit index and is dropped
        mark();
        for (int i = 0; i < 64; i++) send_pixel(ramp(i));
        idle(GAP);
        chk("t7_px_count", px_val_log.size() - px0, 63);
        chk_px("t7", 62, ramp(62), 62);
        chk("t7_err", err_seen - er0, 1);
        chk("t7_fd_count", fd_seen - fd0, 1);
        chk("t7_fpc", fd_cnt_last, 63);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
